fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the instruction memory and drives its `instruction_address`. The memory has a one-cycle registered read. This block owns the program counter, absorbs that read latency, and presents each instruction with its PC and a valid flag to the decoder. It supports stall, zero-bubble redirect (branch/jump) and a sticky halt on a reserved opcode.

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_unit_if.sv | 60 ++++++
 rtl/fetch_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//
// Shared definitions for the instruction fetch stage and its neighbours.
//   FETCH_PC_WIDTH    : default width of the program counter / fetch address
//   FETCH_INSTR_WIDTH : default width of one instruction word
//   RESET_PC          : first fetch address after reset (also used by decoder)
//   HALT_OPCODE       : reserved instruction value that stops fetch for good
//   fetch_state_t     : fetch stage run/halt state
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int FETCH_PC_WIDTH    = 8;
    localparam int FETCH_INSTR_WIDTH = 8;

    localparam logic [FETCH_PC_WIDTH-1:0]    RESET_PC    = 8'h00;
    localparam logic [FETCH_INSTR_WIDTH-1:0] HALT_OPCODE = 8'hFF;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//
// Bundles every signal of the fetch stage except clock and reset.
//   Decoder side : stall, redirect_valid, redirect_target (to fetch)
//                  instr, instr_pc, instr_valid, halted   (from fetch)
//   Memory side  : instruction_address (from fetch, combinational)
//                  instruction_data    (to fetch, one-cycle registered read)
//
// Modports:
//   master : the fetch unit itself
//   slave  : the environment (decoder + instruction memory)
// -----------------------------------------------------------------------------
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH    = FETCH_PC_WIDTH,
    parameter int INSTR_WIDTH = FETCH_INSTR_WIDTH
);

    // Decoder -> fetch
    logic                   stall;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_target;

    // Fetch <-> instruction memory
    logic [PC_WIDTH-1:0]    instruction_address;
    logic [INSTR_WIDTH-1:0] instruction_data;

    // Fetch -> decoder
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    instr_pc;
    logic                   instr_valid;
    logic                   halted;

    modport master (
        input  stall,
        input  redirect_valid,
        input  redirect_target,
        input  instruction_data,
        output instruction_address,
        output instr,
        output instr_pc,
        output instr_valid,
        output halted
    );

    modport slave (
        output stall,
        output redirect_valid,
        output redirect_target,
        output instruction_data,
        input  instruction_address,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        input  halted
    );

endinterface : fetch_unit_if

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage in front of a one-cycle registered instruction
// memory. Owns the program counter, absorbs the memory read latency and
// presents each instruction together with its PC and a valid flag.
// Supports decoder stall, zero-bubble redirect and a sticky halt on a
// reserved opcode.
//
// Ports:
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-high
//   bus    : fetch_unit_if.master
//              stall, redirect_valid, redirect_target  (in)
//              instruction_address                      (out, combinational)
//              instruction_data                         (in, mem[prev address])
//              instr, instr_pc, instr_valid, halted     (out)
//
// Parameters:
//   PC_WIDTH, INSTR_WIDTH, RESET_PC, HALT_OPCODE
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                     PC_WIDTH    = fetch_unit_pkg::FETCH_PC_WIDTH,
    parameter int                     INSTR_WIDTH = fetch_unit_pkg::FETCH_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = fetch_unit_pkg::RESET_PC,
    parameter logic [INSTR_WIDTH-1:0] HALT_OPCODE = fetch_unit_pkg::HALT_OPCODE
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    fetch_state_t           state_q,    state_d;
    logic [PC_WIDTH-1:0]    pc_q,       pc_d;       // next sequential address
    logic [PC_WIDTH-1:0]    pc_d1_q,    pc_d1_d;    // address issued last cycle
    logic                   valid_d1_q, valid_d1_d; // last issue was a real fetch

    // -------------------------------------------------------------------------
    // Combinational decode of the presented instruction and address mux
    // -------------------------------------------------------------------------
    logic                   presenting;   // instr/instr_pc meaningful (pre-reset-mask)
    logic                   halting;      // halt opcode consumed this cycle
    logic                   hold_addr;    // re-issuing pc_d1, so pc must not advance
    logic [PC_WIDTH-1:0]    fetch_addr;

    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a
        // default first, so no path leaves it unassigned and no latch is built.
        presenting = 1'b0;
        halting    = 1'b0;
        hold_addr  = 1'b0;
        fetch_addr = pc_q;

        presenting = valid_d1_q && (state_q == RUN);
        halting    = presenting && !bus.stall && (bus.instruction_data == HALT_OPCODE);

        if (state_q == HALT || halting) begin
            // Halt wins over redirect: park on the halt instruction's address.
            fetch_addr = pc_d1_q;
            hold_addr  = 1'b1;
        end else if (bus.redirect_valid) begin
            // Redirect discards whatever is presented, stalled or not.
            fetch_addr = bus.redirect_target;
        end else if (bus.stall || !valid_d1_q) begin
            // Stall re-reads the presented instruction so it stays on the bus.
            // Right after reset nothing has been fetched yet, so the same
            // re-read path issues RESET_PC (held in pc_d1) as the first fetch
            // while pc already points one past it.
            fetch_addr = pc_d1_q;
            hold_addr  = 1'b1;
        end else begin
            fetch_addr = pc_q;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_d1_d    = pc_d1_q;
        valid_d1_d = valid_d1_q;

        case (state_q)
            RUN: begin
                pc_d1_d    = fetch_addr;
                valid_d1_d = !halting;
                if (!hold_addr) begin
                    // Wraps modulo 2^PC_WIDTH; memory depth is not checked.
                    pc_d = fetch_addr + PC_WIDTH'(1);
                end
                if (halting) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                // Everything frozen; only reset leaves this state.
                valid_d1_d = 1'b0;
            end
            default: begin
                state_d    = RUN;
                valid_d1_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers (synchronous reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC + PC_WIDTH'(1);
            pc_d1_q    <= RESET_PC;
            valid_d1_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_d1_q    <= pc_d1_d;
            valid_d1_q <= valid_d1_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // While reset is high the registers may still hold pre-reset values for
    // one cycle, so the visible outputs are forced to their reset values.
    // Any stall/redirect/halt seen in a reset cycle is thereby discarded.
    always_comb begin
        bus.instruction_address = reset ? RESET_PC : fetch_addr;
        bus.instr               = bus.instruction_data;
        bus.instr_pc            = reset ? RESET_PC : pc_d1_q;
        bus.instr_valid         = presenting && !reset;
        bus.halted              = (state_q == HALT) && !reset;
    end

endmodule : fetch_unit
